fp_seg_display: RTL and testbench

- Downstream consumer of the 12-bit-to-float converter stage.
- Captures the converter's {S, E[2:0], F[3:0]} result on a load strobe and holds it.
- Drives a time-multiplexed 4-digit common-anode 7-segment display on the board.
- Display reads as sign, mantissa hex digit, letter "E", exponent digit, i.e. value = F x 2^E.

---
 rtl/fp_seg_display.sv | 127 ++++++++++++
 tb/tb_fp_seg_display.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fp_seg_display.sv
// Holds the converter's {S, E, F} result and drives a 4-digit multiplexed
// common-anode 7-segment display that reads: sign, F as hex, "E", E as a digit.
module fp_seg_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       s_in,
    input  logic [2:0] e_in,
    input  logic [3:0] f_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       shown
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_BLANK = 7'h7F;
    localparam logic [6:0]       SEG_E     = 7'h06;
    localparam logic [6:0]       SEG_MINUS = 7'h3F;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             s_q, s_d;
    logic [2:0]       e_q, e_d;
    logic [3:0]       f_q, f_d;
    logic             shown_q, shown_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end

        s_d     = s_q;
        e_d     = e_q;
        f_d     = f_q;
        shown_d = shown_q;
        if (load) begin
            s_d     = s_in;
            e_d     = e_in;
            f_d     = f_in;
            shown_d = 1'b1;
        end

        // Output stage looks at the current registered state, giving one cycle of latency.
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (shown_q) begin
            case (idx_q)
                2'd0: begin
                    an_d  = 4'b1110;
                    seg_d = hex_seg({1'b0, e_q});
                end
                2'd1: begin
                    an_d  = 4'b1101;
                    seg_d = SEG_E;
                end
                2'd2: begin
                    an_d  = 4'b1011;
                    seg_d = hex_seg(f_q);
                end
                default: begin
                    an_d  = 4'b0111;
                    seg_d = s_q ? SEG_MINUS : SEG_BLANK;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            s_q     <= 1'b0;
            e_q     <= '0;
            f_q     <= '0;
            shown_q <= 1'b0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            e_q     <= e_d;
            f_q     <= f_d;
            shown_q <= shown_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign dp    = 1'b1;
    assign shown = shown_q;

endmodule

// File: tb/tb_fp_seg_display.sv
// Scoreboard bench for fp_seg_display: the driver predicts each post-edge
// display state from cycle counts and pushes it; a monitor pops and compares.
module tb_fp_seg_display;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       s_in = 1'b0;
    logic [2:0] e_in = '0;
    logic [3:0] f_in = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       shown;

    fp_seg_display #(.REFRESH_DIV(DIV), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .load(load), .s_in(s_in), .e_in(e_in), .f_in(f_in),
        .an(an), .seg(seg), .dp(dp), .shown(shown)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       shown;
    } exp_t;

    exp_t expq[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state as of the last edge: cycles since reset, held value, shown flag.
    int         m_j = 0;
    logic       m_shown = 1'b0;
    logic       m_s = 1'b0;
    logic [2:0] m_e = '0;
    logic [3:0] m_f = '0;

    function automatic int cur_idx();
        return (m_j / DIV) % 4;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (expq.size() > 0) begin
            exp_t x;
            x = expq.pop_front();
            check("an", {4'h0, an}, {4'h0, x.an});
            check("seg", {1'b0, seg}, {1'b0, x.seg});
            check("dp", {7'h0, dp}, 8'h01);
            check("shown", {7'h0, shown}, {7'h0, x.shown});
        end
    end

    task automatic step(input logic r, input logic ld, input logic s,
                        input logic [2:0] e, input logic [3:0] f);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; s_in = s; e_in = e; f_in = f;
        x.an = 4'b1111; x.seg = 7'h7F; x.shown = 1'b0;
        if (!r) begin
            x.shown = m_shown | ld;
            if (m_shown) begin
                case (cur_idx())
                    0: begin x.an = 4'b1110; x.seg = seg_tab[{1'b0, m_e}]; end
                    1: begin x.an = 4'b1101; x.seg = 7'h06; end
                    2: begin x.an = 4'b1011; x.seg = seg_tab[m_f]; end
                    default: begin x.an = 4'b0111; x.seg = m_s ? 7'h3F : 7'h7F; end
                endcase
            end
        end
        expq.push_back(x);
        if (r) begin
            m_j = 0; m_shown = 1'b0; m_s = 1'b0; m_e = '0; m_f = '0;
        end else begin
            m_j++;
            if (ld) begin
                m_shown = 1'b1; m_s = s; m_e = e; m_f = f;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        idle(40);

        step(1'b0, 1'b1, 1'b0, 3'd3, 4'hB);
        idle(20);

        step(1'b0, 1'b1, 1'b1, 3'd7, 4'hF);
        idle(20);

        // load on the edge where cnt==3 and idx steps 1->2
        for (int g = 0; g < 64 && (m_j % 16) != 7; g++) idle(1);
        step(1'b0, 1'b1, 1'b0, 3'd5, 4'h6);
        idle(16);

        step(1'b0, 1'b1, 1'b0, 3'd1, 4'h1);
        step(1'b0, 1'b1, 1'b0, 3'd1, 4'h2);
        idle(20);

        for (int g = 0; g < 64 && cur_idx() != 2; g++) idle(1);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        idle(5);
        step(1'b0, 1'b1, 1'b1, 3'd2, 4'hC);
        idle(20);

        for (int i = 0; i < 2000; i++) begin
            logic r, ld;
            r  = ($urandom_range(99) == 0);
            ld = ($urandom_range(7) == 0);
            step(r, ld, 1'($urandom), 3'($urandom), 4'($urandom));
        end
        idle(2);

        for (int g = 0; g < 10 && expq.size() > 0; g++) @(posedge clk);
        @(negedge clk);
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
